sipo_deserializer: RTL
======================

Name: sipo_deserializer

Overview:
- Receiver-side counterpart to the universal shift register's serial outputs: accepts a qualified serial bit stream and assembles WIDTH-bit words.
- Supports MSB-first (left-shift stream) and LSB-first (right-shift stream) ordering.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- Flags words lost to back-pressure with a sticky overrun bit.

Parameters:
- WIDTH, 4, word width in bits (>=2).
- CNT_W, 2, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  synchronous active-low reset.
- s_din  input  1  serial data bit.
- s_valid  input  1  s_din is sampled on this edge when 1; gaps allowed.
- lsb_first  input  1  1 = first bit received is word bit 0; 0 = first bit is bit WIDTH-1.
- clr  input  1  synchronous abort of the partial word and clear of overrun.
- p_dout  output  WIDTH  assembled word, stable while p_valid=1 and p_ready=0.
- p_valid  output  1  output register holds an unconsumed word.
- p_ready  input  1  consumer accepts p_dout on an edge where p_valid=1 and p_ready=1.
- busy  output  1  partial word in progress (bit count != 0).
- bit_cnt  output  CNT_W  bits accepted into the current word.
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (rst_n=0 at an edge):
  - p_dout=0, p_valid=0, busy=0, bit_cnt=0, overrun=0.
  - Shift register is cleared and the latched order is set to 0.
  - Reset overrides every other input.
- Input FSM states:
  - IDLE (bit_cnt=0): on an edge with s_valid=1, the bit is accepted, lsb_first is latched as the word's order, and the state becomes SHIFT with bit_cnt=1.
  - SHIFT (0<bit_cnt<WIDTH): each s_valid=1 edge accepts one bit and increments bit_cnt.
  - Completion: the edge that accepts the WIDTH-th bit completes the word and returns the FSM to IDLE with bit_cnt=0.
  - s_valid=0 edges hold all state.
- Shifting:
  - Latched order 0: sr <= {sr[WIDTH-2:0], s_din}.
  - Latched order 1: sr <= {s_din, sr[WIDTH-1:1]}.
  - lsb_first changes mid-word are ignored until the next word starts.
- Completion edge, where the word is the assembled value including the current bit:
  - Output empty (p_valid=0), or p_ready=1 on this edge: p_dout <= word and p_valid <= 1. The new word is visible the cycle after the last bit's edge, i.e. latency 1.
  - Output full and p_ready=0: the word is dropped, p_dout is unchanged, and overrun <= 1.
- Handshake:
  - An edge with p_valid=1, p_ready=1 and no completion gives p_valid <= 0.
  - Consumption and completion on the same edge leave p_valid at 1 with the new word; no bubble.
  - p_ready is ignored while p_valid=0.
- clr=1 at an edge:
  - bit_cnt <= 0, busy <= 0, shift register cleared, overrun <= 0.
  - Any s_valid on that edge is discarded.
  - The output register and handshake proceed normally, so a held word survives clr.
- busy equals (bit_cnt != 0).
- Reset mid-word or mid-handshake: the partial word and any held word are discarded.
- Expected size: about 150-250 lines of RTL.

Test Plan:
- MSB-first: WIDTH=4, lsb_first=0, s_valid=1 with bits 1,1,0,1 on consecutive edges, p_ready=1. Required: p_dout=1101 and p_valid=1 one cycle after the 4th bit; bit_cnt sequence 1,2,3,0.
- LSB-first with gaps: lsb_first=1, bits 1,0,1,1 with s_valid=0 for 2 cycles between bits 2 and 3; flip lsb_first to 0 after bit 1. Required: p_dout=1101 (order latched at first bit); bit_cnt holds during the gaps.
- Back-pressure and overrun: p_ready=0, stream words 1101 then 0110. Required: p_dout stays 1101, overrun=1 after the 8th bit, p_valid=1. Then raise p_ready. Required: p_valid=0 next cycle and overrun stays 1 until clr.
- Simultaneous consume and complete: word A=1010 held; assert p_ready on the same edge the 4th bit of B=0011 arrives. Required: p_valid stays 1, p_dout=0011, overrun=0.
- Abort: after 2 bits, clr=1 for one edge, then send 1,0,0,1 MSB-first. Required: bit_cnt=0 and busy=0 after clr, overrun cleared; the next output is 1001.
- Reset mid-operation: rst_n=0 for one edge with 3 bits buffered and p_valid=1. Required: every output is 0 next cycle; a following full 4-bit word assembles correctly.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer: assembles WIDTH-bit words from a
// qualified bit stream (MSB- or LSB-first) and hands them off via valid/ready.
module sipo_deserializer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_din,
    input  logic             s_valid,
    input  logic             lsb_first,
    input  logic             clr,
    output logic [WIDTH-1:0] p_dout,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] sr, sr_nxt, shifted;
    logic             order, order_nxt, cur_order;
    logic             done;

    // The first bit of a word uses the live lsb_first; later bits use the latched order.
    assign cur_order = (state == IDLE) ? lsb_first : order;
    assign shifted   = cur_order ? {s_din, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], s_din};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            order <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sr    <= sr_nxt;
            order <= order_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        order_nxt = order;
        done      = 1'b0;
        if (clr) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            sr_nxt    = '0;
        end else if (s_valid) begin
            sr_nxt = shifted;
            case (state)
                IDLE: begin
                    order_nxt = lsb_first;
                    state_nxt = SHIFT;
                    cnt_nxt   = CNT_W'(1);
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output register: a completing word may replace one being consumed on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_dout  <= '0;
            p_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (done && (!p_valid || p_ready)) begin
                p_dout  <= shifted;
                p_valid <= 1'b1;
            end else if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end
            if (clr)
                overrun <= 1'b0;
            else if (done && p_valid && !p_ready)
                overrun <= 1'b1;
        end
    end

    assign bit_cnt = cnt;
    assign busy    = (cnt != '0);

endmodule
